// File: rtl/multicycle_core_ctrl_if.sv
// Bus bundle between the multicycle sequencer and the instruction/data
// memory ports (IFU/LSU side).
//
// Handshake rules for both request channels (imem_req_*, dmem_req_*):
//   A request transfers on a rising clock edge where valid and ready are both
//   high. Once valid is raised, it stays high and the request payload
//   (imem_req_addr, plus the EXU-driven dmem address/data/op) stays stable
//   until that edge. The memory may hold ready low for any number of cycles.
//   Responses (imem_rsp_*, dmem_rsp_*) are single-cycle strobes with no
//   back-pressure. *_rsp_err and imem_rsp_data mean something only while the
//   matching *_rsp_valid is high.
interface multicycle_core_ctrl_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            imem_rsp_err;

    logic            dmem_req_valid;
    logic            dmem_req_ready;
    logic            dmem_rsp_valid;
    logic            dmem_rsp_err;

    // Core side: issues requests, consumes responses.
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  imem_rsp_err,
        output dmem_req_valid,
        input  dmem_req_ready,
        input  dmem_rsp_valid,
        input  dmem_rsp_err
    );

    // Memory side: accepts requests, produces responses.
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output imem_rsp_err,
        input  dmem_req_valid,
        output dmem_req_ready,
        output dmem_rsp_valid,
        output dmem_rsp_err
    );
endinterface

// File: rtl/multicycle_core_ctrl.sv
// Multi-cycle sequencer for the NPC core.
//
// Walks each instruction through FETCH -> IWAIT -> EXEC -> [MEM -> MWAIT] -> WB
// and owns the PC, the instruction register, the register-file write strobe,
// retire reporting and the halt/fault logic. The IDU/RF/EXU datapath stays
// combinational off inst/pc; this block only decides when things happen.
//
// All outputs are registered. A strobe that belongs to a state (imem_req_valid
// in FETCH, dmem_req_valid in MEM, rf_wen/retire_valid in WB) is set on the
// edge that enters the state and cleared on the edge that leaves it, so it is
// high for exactly the cycles spent in that state.
//
// Coming out of reset the FSM is in FETCH with imem_req_valid low; it spends
// one cycle raising the request before the first fetch can be accepted.
// Every later FETCH is entered from WB with the request already raised, so a
// zero-wait ALU instruction takes 4 cycles and a zero-wait load/store 6.
//
// Wait-state timer: cleared on every state change, counts cycles spent
// without progress in FETCH/IWAIT/MEM/MWAIT. A state may last at most TIMEOUT
// cycles; if the awaited event has not arrived by the last of them the core
// halts with code 3. An event arriving in that last cycle still wins.
// TO_W must satisfy 2**TO_W > TIMEOUT, TIMEOUT >= 1.
//
// state_dbg encoding: 0 FETCH, 1 IWAIT, 2 EXEC, 3 MEM, 4 MWAIT, 5 WB, 6 HALT.
// halt_code: 0 ebreak, 1 imem fault, 2 dmem fault, 3 timeout.
module multicycle_core_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
    parameter int              TIMEOUT  = 255,
    parameter int              TO_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,          // asynchronous, active low

    multicycle_core_ctrl_if.master bus,

    output logic [31:0]          inst,
    output logic [XLEN-1:0]      pc,
    input  logic [XLEN-1:0]      dnpc,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic                 reg_write,
    input  logic                 ebreak,

    output logic                 rf_wen,
    output logic                 retire_valid,
    output logic [XLEN-1:0]      retire_pc,
    output logic [XLEN-1:0]      retire_dnpc,
    output logic                 halted,
    output logic [1:0]           halt_code,

    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        IWAIT = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        MWAIT = 3'd4,
        WB    = 3'd5,
        HALT  = 3'd6
    } state_e;

    localparam logic [1:0] HC_EBREAK  = 2'd0;
    localparam logic [1:0] HC_IMEM    = 2'd1;
    localparam logic [1:0] HC_DMEM    = 2'd2;
    localparam logic [1:0] HC_TIMEOUT = 2'd3;

    // Timer value in the last cycle a wait state is allowed to last.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e          state;
    logic [TO_W-1:0] timer;
    logic [XLEN-1:0] dnpc_q;
    logic            imem_req_valid_q;
    logic            dmem_req_valid_q;

    assign bus.imem_req_valid = imem_req_valid_q;
    assign bus.imem_req_addr  = pc;
    assign bus.dmem_req_valid = dmem_req_valid_q;
    assign state_dbg          = state;

    // Sequencer: state, architectural registers and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= FETCH;
            timer            <= '0;
            pc               <= RESET_PC;
            inst             <= '0;
            dnpc_q           <= '0;
            imem_req_valid_q <= 1'b0;
            dmem_req_valid_q <= 1'b0;
            rf_wen           <= 1'b0;
            retire_valid     <= 1'b0;
            retire_pc        <= '0;
            retire_dnpc      <= '0;
            halted           <= 1'b0;
            halt_code        <= HC_EBREAK;
        end else begin
            // WB strobes are one-cycle pulses unless re-armed below.
            rf_wen       <= 1'b0;
            retire_valid <= 1'b0;

            case (state)
                FETCH: begin
                    if (!imem_req_valid_q) begin
                        // First fetch after reset: raise the request.
                        imem_req_valid_q <= 1'b1;
                    end else if (bus.imem_req_ready) begin
                        // Any response in this same cycle is ignored.
                        imem_req_valid_q <= 1'b0;
                        timer            <= '0;
                        state            <= IWAIT;
                    end else if (timer == TO_LAST) begin
                        imem_req_valid_q <= 1'b0;
                        timer            <= '0;
                        halted           <= 1'b1;
                        halt_code        <= HC_TIMEOUT;
                        state            <= HALT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                IWAIT: begin
                    if (bus.imem_rsp_valid) begin
                        timer <= '0;
                        if (bus.imem_rsp_err) begin
                            halted    <= 1'b1;
                            halt_code <= HC_IMEM;
                            state     <= HALT;
                        end else begin
                            inst  <= bus.imem_rsp_data;
                            state <= EXEC;
                        end
                    end else if (timer == TO_LAST) begin
                        timer     <= '0;
                        halted    <= 1'b1;
                        halt_code <= HC_TIMEOUT;
                        state     <= HALT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                EXEC: begin
                    dnpc_q <= dnpc;
                    timer  <= '0;
                    if (ebreak) begin
                        // No retire for ebreak; pc stays on the ebreak.
                        halted    <= 1'b1;
                        halt_code <= HC_EBREAK;
                        state     <= HALT;
                    end else if (is_load || is_store) begin
                        dmem_req_valid_q <= 1'b1;
                        state            <= MEM;
                    end else begin
                        rf_wen       <= reg_write && !is_store;
                        retire_valid <= 1'b1;
                        retire_pc    <= pc;
                        retire_dnpc  <= dnpc;
                        state        <= WB;
                    end
                end

                MEM: begin
                    if (bus.dmem_req_ready) begin
                        dmem_req_valid_q <= 1'b0;
                        timer            <= '0;
                        state            <= MWAIT;
                    end else if (timer == TO_LAST) begin
                        dmem_req_valid_q <= 1'b0;
                        timer            <= '0;
                        halted           <= 1'b1;
                        halt_code        <= HC_TIMEOUT;
                        state            <= HALT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                MWAIT: begin
                    if (bus.dmem_rsp_valid) begin
                        timer <= '0;
                        if (bus.dmem_rsp_err) begin
                            halted    <= 1'b1;
                            halt_code <= HC_DMEM;
                            state     <= HALT;
                        end else begin
                            rf_wen       <= reg_write && !is_store;
                            retire_valid <= 1'b1;
                            retire_pc    <= pc;
                            retire_dnpc  <= dnpc_q;
                            state        <= WB;
                        end
                    end else if (timer == TO_LAST) begin
                        timer     <= '0;
                        halted    <= 1'b1;
                        halt_code <= HC_TIMEOUT;
                        state     <= HALT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                WB: begin
                    // Raise the next fetch on the way out so FETCH costs one cycle.
                    pc               <= dnpc_q;
                    imem_req_valid_q <= 1'b1;
                    timer            <= '0;
                    state            <= FETCH;
                end

                HALT: begin
                    // Absorbing: only reset leaves this state.
                    imem_req_valid_q <= 1'b0;
                    dmem_req_valid_q <= 1'b0;
                    halted           <= 1'b1;
                end

                default: begin
                    imem_req_valid_q <= 1'b0;
                    dmem_req_valid_q <= 1'b0;
                    timer            <= '0;
                    halted           <= 1'b1;
                    halt_code        <= HC_TIMEOUT;
                    state            <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_core_ctrl.sv
// Bench for multicycle_core_ctrl: table of hand-computed instruction records,
// hand-written reset/halt/timeout sequences, then random instructions checked
// against a latency/write-enable model derived from the phase rules.
module tb_multicycle_core_ctrl;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          TIMEOUT  = 255;
  localparam int          W        = 97;   // {inst, retire_pc, retire_dnpc, rf_wen}
  localparam int          N_TBL    = 10;
  localparam int          N_RAND   = 40;

  typedef struct {
    logic        ld;
    logic        st;
    logic        rw;
    logic        eb;
    logic [31:0] dn;
    logic [31:0] iw;
    int          d_f;      // cycles imem holds ready low
    int          d_i;      // cycles before imem response
    int          d_m;      // cycles dmem holds ready low
    int          d_r;      // cycles before dmem response
    logic        junk;     // inject responses that must be ignored
    logic        exp_wen;
    int          exp_lat;  // cycles from first fetch-valid cycle to retire cycle, inclusive
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] dnpc;
  logic        is_load;
  logic        is_store;
  logic        reg_write;
  logic        ebreak;
  logic        rf_wen;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [31:0] retire_dnpc;
  logic        halted;
  logic [1:0]  halt_code;
  logic [2:0]  state_dbg;

  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  logic [31:0] model_pc = RESET_PC;
  logic [W-1:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [W-1:0] mon_e;
  int          mon_c;
  vec_t        tbl[N_TBL];
  vec_t        rv;
  int          t_dummy;
  int          kind;

  multicycle_core_ctrl_if #(.XLEN(XLEN)) bus ();

  multicycle_core_ctrl #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT), .TO_W(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .inst(inst), .pc(pc), .dnpc(dnpc),
    .is_load(is_load), .is_store(is_store), .reg_write(reg_write), .ebreak(ebreak),
    .rf_wen(rf_wen), .retire_valid(retire_valid),
    .retire_pc(retire_pc), .retire_dnpc(retire_dnpc),
    .halted(halted), .halt_code(halt_code), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every retire must match the oldest expectation, in the expected cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (retire_valid) begin
        check("retire_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          mon_c = exp_cyc_q.pop_front();
          check("retire_record", {inst, retire_pc, retire_dnpc, rf_wen}, mon_e);
          check("retire_cycle", cyc, mon_c);
        end
      end
      if (rf_wen) check("rf_wen_with_retire", retire_valid, 1'b1);
    end
  end

  // ---------------- model ----------------
  function automatic int model_lat(input logic mem, input int d_f, d_i, d_m, d_r);
    int lat;
    lat = (d_f + 1) + (d_i + 1) + 1 + 1;
    if (mem) lat += (d_m + 1) + (d_r + 1);
    return lat;
  endfunction

  function automatic logic model_wen(input logic rw, input logic st);
    return rw && !st;
  endfunction

  function automatic vec_t mk(input logic ld, st, rw, eb, input logic [31:0] dn, iw,
                              input int d_f, d_i, d_m, d_r, input logic junk,
                              input logic exp_wen, input int exp_lat);
    vec_t v;
    v.ld = ld; v.st = st; v.rw = rw; v.eb = eb; v.dn = dn; v.iw = iw;
    v.d_f = d_f; v.d_i = d_i; v.d_m = d_m; v.d_r = d_r; v.junk = junk;
    v.exp_wen = exp_wen; v.exp_lat = exp_lat;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic probe(input int s);
    case (s)
      0:       return bus.imem_req_valid;
      1:       return bus.dmem_req_valid;
      2:       return retire_valid;
      default: return halted;
    endcase
  endfunction

  task automatic wait_for(input int s, input string name, input int bound);
    for (int i = 0; i < bound && !probe(s); i++) tick();
    check(name, probe(s), 1'b1);
  endtask

  task automatic clear_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_err   = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.dmem_req_ready = 1'b0;
    bus.dmem_rsp_valid = 1'b0;
    bus.dmem_rsp_err   = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_pc", pc, RESET_PC);
    check("rst_inst", inst, 32'h0);
    check("rst_state", state_dbg, 3'd0);
    check("rst_imem_valid", bus.imem_req_valid, 1'b0);
    check("rst_dmem_valid", bus.dmem_req_valid, 1'b0);
    check("rst_rf_wen", rf_wen, 1'b0);
    check("rst_retire", retire_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_halt_code", halt_code, 2'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    check_reset_values();
    tick();
    rst = 1'b1;
    model_pc = RESET_PC;
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  // Accept one fetch after d cycles of back-pressure. Ends in the first IWAIT cycle.
  task automatic imem_accept(input int d, input logic junk, output int t0);
    logic [31:0] a;
    wait_for(0, "imem_req_valid_rise", 8);
    t0 = cyc;
    a = bus.imem_req_addr;
    check("fetch_addr", a, model_pc);
    for (int i = 0; i < d; i++) begin
      tick();
      check("imem_valid_held", bus.imem_req_valid, 1'b1);
      check("imem_addr_stable", bus.imem_req_addr, a);
    end
    bus.imem_req_ready = 1'b1;
    if (junk) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_err   = 1'b1;
      bus.imem_rsp_data  = 32'hdead_beef;
    end
    tick();
    clear_inputs();
    check("imem_valid_drop", bus.imem_req_valid, 1'b0);
  endtask

  task automatic imem_respond(input int d, input logic [31:0] data, input logic err);
    for (int i = 0; i < d; i++) tick();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = data;
    bus.imem_rsp_err   = err;
    tick();
    clear_inputs();
  endtask

  // Accept one data request after d cycles of back-pressure. Ends in the first MWAIT cycle.
  task automatic dmem_accept(input int d, input logic junk);
    wait_for(1, "dmem_req_valid_rise", 4);
    for (int i = 0; i < d; i++) begin
      tick();
      check("dmem_valid_held", bus.dmem_req_valid, 1'b1);
    end
    bus.dmem_req_ready = 1'b1;
    if (junk) begin
      bus.dmem_rsp_valid = 1'b1;
      bus.dmem_rsp_err   = 1'b1;
    end
    tick();
    clear_inputs();
    check("dmem_valid_drop", bus.dmem_req_valid, 1'b0);
  endtask

  task automatic dmem_respond(input int d, input logic err);
    for (int i = 0; i < d; i++) tick();
    bus.dmem_rsp_valid = 1'b1;
    bus.dmem_rsp_err   = err;
    tick();
    clear_inputs();
  endtask

  task automatic run_instr(input vec_t v);
    int t0;
    is_load   = v.ld;
    is_store  = v.st;
    reg_write = v.rw;
    ebreak    = v.eb;
    dnpc      = v.dn;
    imem_accept(v.d_f, v.junk, t0);
    if (!v.eb) begin
      exp_q.push_back({v.iw, model_pc, v.dn, v.exp_wen});
      exp_cyc_q.push_back(t0 + v.exp_lat - 1);
    end
    imem_respond(v.d_i, v.iw, 1'b0);
    if (v.eb) begin
      wait_for(3, "ebreak_halt", 4);
      check("ebreak_halt_code", halt_code, 2'd0);
      for (int i = 0; i < 6; i++) begin
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        tick();
        check("halt_no_fetch", bus.imem_req_valid, 1'b0);
        check("halt_pc_frozen", pc, model_pc);
        check("halt_sticky", halted, 1'b1);
      end
      clear_inputs();
    end else begin
      if (v.ld || v.st) begin
        dmem_accept(v.d_m, v.junk);
        dmem_respond(v.d_r, 1'b0);
      end
      wait_for(2, "retire_seen", 4);
      check("pc_at_retire", pc, model_pc);
      model_pc = v.dn;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    clear_inputs();
    is_load = 1'b0; is_store = 1'b0; reg_write = 1'b0; ebreak = 1'b0; dnpc = 32'h0;
    tick();
    do_reset();

    // Reset in the middle of a fetch: request abandoned, nothing retires.
    imem_accept(0, 1'b0, t_dummy);
    do_reset();
    // A stray response while FETCH is still raising its request must be ignored.
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_err   = 1'b1;
    bus.imem_rsp_data  = 32'hbad0_0bad;
    tick();
    clear_inputs();

    //            ld    st    rw    eb    dnpc          inst          dF dI dM dR junk  wen  lat
    tbl[0] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0004, 32'h0010_0093, 0, 0, 0, 0, 1'b0, 1'b1, 4);  // addi
    tbl[1] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0008, 32'h0000_a103, 0, 0, 3, 2, 1'b0, 1'b1, 11); // lw, slow dmem
    tbl[2] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_000c, 32'h0020_a023, 0, 0, 0, 0, 1'b0, 1'b0, 6);  // sw
    tbl[3] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0100, 32'h0f40_006f, 0, 0, 0, 0, 1'b0, 1'b1, 4);  // jal
    tbl[4] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0104, 32'h0020_81b3, 2, 3, 0, 0, 1'b1, 1'b1, 9);  // add, slow imem
    tbl[5] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'hffff_fffc, 32'h0000_0463, 1, 0, 0, 0, 1'b0, 1'b0, 5);  // branch
    tbl[6] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0013, 0, 0, 0, 0, 1'b0, 1'b1, 4);  // pc wraps
    tbl[7] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0040_2203, 1, 1, 0, 1, 1'b1, 1'b1, 9);  // lw at 0
    tbl[8] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0040_2423, 0, 0, 2, 0, 1'b0, 1'b0, 8);  // sw, slow ready
    tbl[9] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_000c, 32'h0000_2003, 0, 0, 0, 0, 1'b1, 1'b0, 6);  // lw x0
    for (int i = 0; i < N_TBL; i++) run_instr(tbl[i]);

    // ebreak: halts with code 0, no retire, pc frozen.
    run_instr(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0010_0073, 0, 0, 0, 0, 1'b0, 1'b0, 0));
    do_reset();

    // Instruction fetch fault.
    imem_accept(0, 1'b0, t_dummy);
    imem_respond(1, 32'h0000_0013, 1'b1);
    check("imem_err_halted", halted, 1'b1);
    check("imem_err_code", halt_code, 2'd1);
    check("imem_err_pc", pc, RESET_PC);
    check("imem_err_no_fetch", bus.imem_req_valid, 1'b0);
    do_reset();

    // Data fault.
    is_load = 1'b1; is_store = 1'b0; reg_write = 1'b1; ebreak = 1'b0; dnpc = RESET_PC + 32'd4;
    imem_accept(0, 1'b0, t_dummy);
    imem_respond(0, 32'h0000_a103, 1'b0);
    dmem_accept(0, 1'b0);
    dmem_respond(2, 1'b1);
    check("dmem_err_halted", halted, 1'b1);
    check("dmem_err_code", halt_code, 2'd2);
    check("dmem_err_pc", pc, RESET_PC);
    do_reset();

    // dmem never responds: 255 wait cycles allowed, halt code 3 right after.
    imem_accept(0, 1'b0, t_dummy);
    imem_respond(0, 32'h0000_a103, 1'b0);
    dmem_accept(0, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("dmem_no_early_timeout", halted, 1'b0);
    tick();
    check("dmem_timeout_halted", halted, 1'b1);
    check("dmem_timeout_code", halt_code, 2'd3);
    check("dmem_timeout_no_req", bus.dmem_req_valid, 1'b0);
    do_reset();

    // Response in the 255th wait cycle wins over the timeout.
    rv = mk(1'b1, 1'b0, 1'b1, 1'b0, RESET_PC + 32'd4, 32'h0000_a103, 0, 0, 0, TIMEOUT - 1, 1'b0,
            1'b1, 1 + 1 + 1 + 1 + TIMEOUT + 1);
    run_instr(rv);
    check("late_rsp_not_halted", halted, 1'b0);
    do_reset();

    // imem never responds.
    imem_accept(0, 1'b0, t_dummy);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("imem_no_early_timeout", halted, 1'b0);
    tick();
    check("imem_timeout_halted", halted, 1'b1);
    check("imem_timeout_code", halt_code, 2'd3);
    do_reset();

    // Random instruction stream against the model.
    for (int i = 0; i < N_RAND; i++) begin
      kind   = int'($urandom_range(0, 2));
      rv.ld  = (kind == 1);
      rv.st  = (kind == 2);
      rv.rw  = 1'($urandom_range(0, 1));
      rv.eb  = 1'b0;
      rv.dn  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hffff_fffc) : model_pc + 32'd4;
      rv.iw  = $urandom;
      rv.d_f = int'($urandom_range(0, 3));
      rv.d_i = int'($urandom_range(0, 3));
      rv.d_m = int'($urandom_range(0, 3));
      rv.d_r = int'($urandom_range(0, 3));
      rv.junk    = 1'($urandom_range(0, 1));
      rv.exp_wen = model_wen(rv.rw, rv.st);
      rv.exp_lat = model_lat(rv.ld || rv.st, rv.d_f, rv.d_i, rv.d_m, rv.d_r);
      run_instr(rv);
    end

    tick();
    check("scoreboard_drained", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
